// File: rtl/mem_stage_oq_pkg.sv
// Shared definitions for the in-order memory stage queue: load-op encoding
// and the per-entry record (sideband is kept apart because its width is a parameter).
package mem_stage_oq_pkg;

  localparam int LD_OP_W    = 5;
  localparam int LD_B       = 0;
  localparam int LD_BU      = 1;
  localparam int LD_H       = 2;
  localparam int LD_HU      = 3;
  localparam int LD_W       = 4;
  localparam int SIDE_W_DEF = 137;

  typedef struct packed {
    logic               is_mem;
    logic               res_from_mem;
    logic [LD_OP_W-1:0] ld_op;
    logic               gr_we;
    logic [4:0]         dest;
    logic [31:0]        result;
    logic               ex;
    logic               csr;
    logic               done;
    logic [31:0]        data;
  } entry_t;

endpackage

// File: rtl/mem_stage_oq_ld_align.sv
// Combinational load alignment: picks the addressed byte/half of the
// response word and sign- or zero-extends it according to the load op.
module mem_stage_oq_ld_align
  import mem_stage_oq_pkg::*;
(
  input  logic [31:0]        rdata_i,
  input  logic [1:0]         addr_i,
  input  logic [LD_OP_W-1:0] ld_op_i,
  output logic [31:0]        result_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    case (addr_i)
      2'd0:    byte_v = rdata_i[7:0];
      2'd1:    byte_v = rdata_i[15:8];
      2'd2:    byte_v = rdata_i[23:16];
      default: byte_v = rdata_i[31:24];
    endcase
    half_v = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    result_o = rdata_i;
    if (ld_op_i[LD_W])       result_o = rdata_i;
    else if (ld_op_i[LD_B])  result_o = {{24{byte_v[7]}}, byte_v};
    else if (ld_op_i[LD_BU]) result_o = {24'h0, byte_v};
    else if (ld_op_i[LD_H])  result_o = {{16{half_v[15]}}, half_v};
    else if (ld_op_i[LD_HU]) result_o = {16'h0, half_v};
  end

endmodule

// File: rtl/mem_stage_oq.sv
// MEM stage with an in-order queue of in-flight instructions; responses fill
// the oldest waiting mem entry, and a flush turns owed responses into discards.
module mem_stage_oq
  import mem_stage_oq_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int SIDE_W = SIDE_W_DEF,
  parameter int DISC_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_is_mem,
  input  logic               in_res_from_mem,
  input  logic [LD_OP_W-1:0] in_ld_op,
  input  logic               in_gr_we,
  input  logic [4:0]         in_dest,
  input  logic [31:0]        in_result,
  input  logic [SIDE_W-1:0]  in_side,
  input  logic               in_ex,
  input  logic               in_csr,
  input  logic               data_ok,
  input  logic [31:0]        rdata,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_gr_we,
  output logic [4:0]         out_dest,
  output logic [31:0]        out_result,
  output logic [SIDE_W-1:0]  out_side,
  output logic [31:0]        wr_pending,
  output logic               ex_pending,
  output logic               csr_pending
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = ((DISC_W > CNT_W) ? DISC_W : CNT_W) + 1;

  entry_t            ent_q  [DEPTH];
  logic [SIDE_W-1:0] side_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DISC_W-1:0] disc_q, disc_d;

  logic [PTR_W-1:0]  idx, resp_ptr;
  logic              resp_found, resp_we, hit, enq, deq;
  logic [CNT_W-1:0]  outstanding;
  logic [31:0]       aligned, resp_data;
  logic [SUM_W-1:0]  disc_sum;
  entry_t            new_ent;

  // Entries are contiguous from head, so the first waiting mem entry is the oldest.
  always_comb begin
    idx         = head_q;
    resp_ptr    = head_q;
    resp_found  = 1'b0;
    outstanding = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (valid_q[idx] && ent_q[idx].is_mem && !ent_q[idx].done) begin
        outstanding = outstanding + CNT_W'(1);
        if (!resp_found) begin
          resp_found = 1'b1;
          resp_ptr   = idx;
        end
      end
    end
  end

  mem_stage_oq_ld_align u_align (
    .rdata_i  (rdata),
    .addr_i   (ent_q[resp_ptr].result[1:0]),
    .ld_op_i  (ent_q[resp_ptr].ld_op),
    .result_o (aligned)
  );

  assign resp_data = ent_q[resp_ptr].res_from_mem ? aligned : ent_q[resp_ptr].data;
  assign resp_we   = data_ok && (disc_q == '0) && resp_found;
  assign hit       = resp_we && (resp_ptr == head_q);
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = !flush && valid_q[head_q] && (ent_q[head_q].done || hit);
  assign deq       = out_valid && out_ready;
  assign enq       = in_valid && in_ready && !flush;

  always_comb begin
    new_ent              = '0;
    new_ent.is_mem       = in_is_mem;
    new_ent.res_from_mem = in_res_from_mem;
    new_ent.ld_op        = in_ld_op;
    new_ent.gr_we        = in_gr_we;
    new_ent.dest         = in_dest;
    new_ent.result       = in_result;
    new_ent.ex           = in_ex;
    new_ent.csr          = in_csr;
    new_ent.done         = !in_is_mem;
    new_ent.data         = in_result;
  end

  // On flush every response still owed becomes a discard; one arriving now pays one off.
  always_comb begin
    disc_sum = SUM_W'(disc_q) + SUM_W'(outstanding);
    if (data_ok && (disc_sum != '0)) disc_sum = disc_sum - SUM_W'(1);
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    disc_d  = disc_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      disc_d  = (disc_sum > SUM_W'({DISC_W{1'b1}})) ? {DISC_W{1'b1}} : disc_sum[DISC_W-1:0];
    end else begin
      if (deq) head_d = head_q + PTR_W'(1);
      if (enq) tail_d = tail_q + PTR_W'(1);
      count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
      if (data_ok && (disc_q != '0)) disc_d = disc_q - DISC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      disc_q  <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      disc_q  <= disc_d;
      if (flush) begin
        valid_q <= '0;
      end else begin
        if (deq) valid_q[head_q] <= 1'b0;
        if (enq) valid_q[tail_q] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!flush && resp_we) begin
      ent_q[resp_ptr].done <= 1'b1;
      ent_q[resp_ptr].data <= resp_data;
    end
    if (enq) begin
      ent_q[tail_q]  <= new_ent;
      side_q[tail_q] <= in_side;
    end
  end

  always_comb begin
    out_gr_we  = 1'b0;
    out_dest   = '0;
    out_result = '0;
    out_side   = '0;
    if (out_valid) begin
      out_gr_we  = ent_q[head_q].gr_we;
      out_dest   = ent_q[head_q].dest;
      out_result = hit ? resp_data : ent_q[head_q].data;
      out_side   = side_q[head_q];
    end
  end

  always_comb begin
    wr_pending  = '0;
    ex_pending  = 1'b0;
    csr_pending = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) begin
        if (ent_q[i].gr_we) wr_pending[ent_q[i].dest] = 1'b1;
        if (ent_q[i].ex)    ex_pending  = 1'b1;
        if (ent_q[i].csr)   csr_pending = 1'b1;
      end
    end
    wr_pending[0] = 1'b0;
  end

endmodule

// File: tb/tb_mem_stage_oq.sv
// Bench for mem_stage_oq: alignment vector table, directed multi-cycle
// sequences, then randomized traffic against a queue-based reference model.
module tb_mem_stage_oq;
  localparam int DEPTH  = 4;
  localparam int SIDE_W = 137;
  localparam int DISC_W = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid, in_ready, in_is_mem, in_res_from_mem;
  logic [4:0]        in_ld_op, in_dest;
  logic              in_gr_we, in_ex, in_csr;
  logic [31:0]       in_result;
  logic [SIDE_W-1:0] in_side;
  logic              data_ok, flush, out_valid, out_ready, out_gr_we;
  logic [31:0]       rdata, out_result, wr_pending;
  logic [4:0]        out_dest;
  logic [SIDE_W-1:0] out_side;
  logic              ex_pending, csr_pending;

  mem_stage_oq #(.DEPTH(DEPTH), .SIDE_W(SIDE_W), .DISC_W(DISC_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_is_mem(in_is_mem),
    .in_res_from_mem(in_res_from_mem), .in_ld_op(in_ld_op), .in_gr_we(in_gr_we),
    .in_dest(in_dest), .in_result(in_result), .in_side(in_side), .in_ex(in_ex),
    .in_csr(in_csr), .data_ok(data_ok), .rdata(rdata), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_gr_we(out_gr_we),
    .out_dest(out_dest), .out_result(out_result), .out_side(out_side),
    .wr_pending(wr_pending), .ex_pending(ex_pending), .csr_pending(csr_pending)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [4:0]  op;
    logic [1:0]  addr;
    logic [31:0] rd;
    logic [31:0] exp;
  } al_vec_t;

  typedef struct {
    logic              is_mem, rfm, gr_we, ex, csr, done;
    logic [4:0]        ld_op, dest;
    logic [31:0]       result, data;
    logic [SIDE_W-1:0] side;
  } m_ent_t;

  m_ent_t mq[$];
  int     m_disc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_side(input string nm, input logic [SIDE_W-1:0] act, input logic [SIDE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [SIDE_W-1:0] rand_side();
    logic [SIDE_W-1:0] s;
    s = '0;
    for (int i = 0; i < SIDE_W; i += 32) s = {s[SIDE_W-33:0], $urandom()};
    return s;
  endfunction

  // Reference alignment from plain arithmetic on shifted words.
  function automatic logic [31:0] m_align(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] rd);
    int unsigned v;
    if (op[0] || op[1]) begin
      v = (rd >> (8 * addr[1:0])) % 256;
      return (op[0] && v >= 128) ? v - 256 : v;
    end
    if (op[2] || op[3]) begin
      v = (rd >> (16 * addr[1])) % 65536;
      return (op[2] && v >= 32768) ? v - 65536 : v;
    end
    return rd;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; in_is_mem = 0; in_res_from_mem = 0; in_ld_op = '0; in_gr_we = 0;
    in_dest = '0; in_result = '0; in_side = '0; in_ex = 0; in_csr = 0;
    data_ok = 0; rdata = '0; flush = 0;
  endtask

  task automatic issue(input logic is_mem, input logic rfm, input logic [4:0] op, input logic gr_we,
                       input logic [4:0] dest, input logic [31:0] res, input logic ex, input logic csr,
                       input logic [SIDE_W-1:0] side);
    in_valid = 1; in_is_mem = is_mem; in_res_from_mem = rfm; in_ld_op = op; in_gr_we = gr_we;
    in_dest = dest; in_result = res; in_ex = ex; in_csr = csr; in_side = side;
    tick();
    in_valid = 0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, ".in_ready"},    32'(in_ready), 32'd1);
    chk({tag, ".out_valid"},   32'(out_valid), 32'd0);
    chk({tag, ".wr_pending"},  wr_pending, 32'd0);
    chk({tag, ".ex_pending"},  32'(ex_pending), 32'd0);
    chk({tag, ".csr_pending"}, 32'(csr_pending), 32'd0);
    chk({tag, ".out_gr_we"},   32'(out_gr_we), 32'd0);
    chk({tag, ".out_dest"},    32'(out_dest), 32'd0);
    chk({tag, ".out_result"},  out_result, 32'd0);
    chk_side({tag, ".out_side"}, out_side, '0);
  endtask

  initial begin
    al_vec_t           vt[10];
    logic [SIDE_W-1:0] sd;

    idle();
    out_ready = 1;
    reset = 1;
    repeat (3) @(posedge clk);
    #1;
    reset = 0;
    #1;
    chk_reset_outs("reset");

    // alignment table: one load, response the next cycle, bypass result checked
    vt[0] = '{5'b00001, 2'd3, 32'h80FF_FF7F, 32'hFFFF_FF80};
    vt[1] = '{5'b01000, 2'd2, 32'h80FF_FF7F, 32'h0000_80FF};
    vt[2] = '{5'b00001, 2'd0, 32'h80FF_FF7F, 32'h0000_007F};
    vt[3] = '{5'b00010, 2'd1, 32'h80FF_FF7F, 32'h0000_00FF};
    vt[4] = '{5'b00100, 2'd0, 32'h1234_8001, 32'hFFFF_8001};
    vt[5] = '{5'b00100, 2'd2, 32'h1234_8001, 32'h0000_1234};
    vt[6] = '{5'b01000, 2'd0, 32'h1234_8001, 32'h0000_8001};
    vt[7] = '{5'b00000, 2'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vt[8] = '{5'b00010, 2'd3, 32'h80FF_FF7F, 32'h0000_0080};
    vt[9] = '{5'b00001, 2'd2, 32'h00AB_0000, 32'hFFFF_FFAB};
    for (int i = 0; i < 10; i++) begin
      issue(1, 1, vt[i].op, 1, 5'(i + 1), {28'h000_0100, 2'b00, vt[i].addr}, 0, 0, rand_side());
      chk("tbl.wait", 32'(out_valid), 32'd0);
      data_ok = 1; rdata = vt[i].rd;
      #1;
      chk("tbl.valid", 32'(out_valid), 32'd1);
      chk("tbl.result", out_result, vt[i].exp);
      tick();
      data_ok = 0;
    end

    // ld.b at ..3, response three cycles after issue
    issue(1, 1, 5'b00001, 1, 5'd3, 32'h0000_2003, 0, 0, rand_side());
    #1; chk("ldb.c1", 32'(out_valid), 32'd0);
    tick(); chk("ldb.c2", 32'(out_valid), 32'd0);
    tick();
    data_ok = 1; rdata = 32'h80FF_FF7F;
    #1;
    chk("ldb.valid", 32'(out_valid), 32'd1);
    chk("ldb.result", out_result, 32'hFFFF_FF80);
    chk("ldb.dest", 32'(out_dest), 32'd3);
    tick(); data_ok = 0;
    #1; chk("ldb.after", 32'(out_valid), 32'd0);

    // four back-to-back loads fill the queue, responses drain one per cycle
    for (int i = 0; i < 4; i++) begin
      chk("fill.ready", 32'(in_ready), 32'd1);
      issue(1, 1, 5'b00000, 1, 5'(i + 1), 32'h0000_3000, 0, 0, rand_side());
    end
    #1;
    chk("full.ready", 32'(in_ready), 32'd0);
    chk("full.valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      data_ok = 1; rdata = 32'(8'h11 * (i + 1));
      #1;
      chk("drain.valid", 32'(out_valid), 32'd1);
      chk("drain.result", out_result, 32'(8'h11 * (i + 1)));
      chk("drain.dest", 32'(out_dest), 32'(i + 1));
      if (i == 0) chk("drain.ready_at_full", 32'(in_ready), 32'd0);
      tick();
    end
    data_ok = 0;
    #1; chk("drain.empty", 32'(out_valid), 32'd0);

    // alu / load / alu: younger alu must wait behind the load
    out_ready = 0;
    issue(0, 0, 5'b0, 1, 5'd5, 32'h0000_0555, 0, 0, rand_side());
    issue(1, 1, 5'b0, 1, 5'd6, 32'h0000_4000, 0, 0, rand_side());
    issue(0, 0, 5'b0, 1, 5'd7, 32'h0000_0777, 0, 0, rand_side());
    #1;
    chk("mix.wr_pending", wr_pending, 32'h0000_00E0);
    chk("mix.head_dest", 32'(out_dest), 32'd5);
    out_ready = 1;
    tick();
    chk("mix.load_wait1", 32'(out_valid), 32'd0);
    tick();
    chk("mix.load_wait2", 32'(out_valid), 32'd0);
    chk("mix.wr_pending2", wr_pending, 32'h0000_00C0);
    data_ok = 1; rdata = 32'h0000_0066;
    #1;
    chk("mix.load_out", 32'(out_valid), 32'd1);
    chk("mix.load_dest", 32'(out_dest), 32'd6);
    chk("mix.load_res", out_result, 32'h0000_0066);
    tick(); data_ok = 0;
    #1;
    chk("mix.alu7_dest", 32'(out_dest), 32'd7);
    chk("mix.alu7_res", out_result, 32'h0000_0777);
    tick();
    chk("mix.empty_wp", wr_pending, 32'd0);

    // flush with two loads owed and a response in the flush cycle
    issue(1, 1, 5'b0, 1, 5'd8, 32'h0000_5000, 0, 0, rand_side());
    issue(1, 1, 5'b0, 1, 5'd9, 32'h0000_5004, 0, 0, rand_side());
    flush = 1; data_ok = 1; rdata = 32'h0000_5555;
    #1;
    chk("flush.out_valid", 32'(out_valid), 32'd0);
    tick(); flush = 0; data_ok = 0;
    #1;
    chk("flush.wr_pending", wr_pending, 32'd0);
    chk("flush.in_ready", 32'(in_ready), 32'd1);
    issue(1, 1, 5'b0, 1, 5'd10, 32'h0000_6000, 0, 0, rand_side());
    data_ok = 1; rdata = 32'h0000_DEAD;
    #1;
    chk("flush.dropped", 32'(out_valid), 32'd0);
    chk("flush.fresh_wp", wr_pending, 32'h0000_0400);
    tick();
    rdata = 32'h0000_1234;
    #1;
    chk("flush.fresh_valid", 32'(out_valid), 32'd1);
    chk("flush.fresh_res", out_result, 32'h0000_1234);
    tick(); data_ok = 0;

    // store waits for its response and keeps its address as result
    issue(1, 0, 5'b0, 0, 5'd11, 32'h0000_0100, 0, 0, rand_side());
    #1; chk("st.wait1", 32'(out_valid), 32'd0);
    tick(); chk("st.wait2", 32'(out_valid), 32'd0);
    data_ok = 1; rdata = 32'hFFFF_FFFF;
    #1;
    chk("st.valid", 32'(out_valid), 32'd1);
    chk("st.result", out_result, 32'h0000_0100);
    chk("st.gr_we", 32'(out_gr_we), 32'd0);
    tick(); data_ok = 0;

    // back-pressure: head stays put for five cycles
    out_ready = 0;
    sd = rand_side();
    issue(0, 0, 5'b0, 1, 5'd12, 32'h0000_CAFE, 0, 0, sd);
    issue(0, 0, 5'b0, 1, 5'd13, 32'h0000_BEEF, 1, 0, rand_side());
    issue(1, 1, 5'b0, 1, 5'd14, 32'h0000_7000, 0, 1, rand_side());
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall.valid", 32'(out_valid), 32'd1);
      chk("stall.dest", 32'(out_dest), 32'd12);
      chk("stall.result", out_result, 32'h0000_CAFE);
      chk_side("stall.side", out_side, sd);
      tick();
    end
    chk("stall.ex_pending", 32'(ex_pending), 32'd1);
    chk("stall.csr_pending", 32'(csr_pending), 32'd1);
    reset = 1;
    tick();
    reset = 0;
    #1;
    chk_reset_outs("midreset");

    // reset must also clear discards left by a flush
    out_ready = 1;
    issue(1, 1, 5'b0, 1, 5'd15, 32'h0, 0, 0, rand_side());
    issue(1, 1, 5'b0, 1, 5'd16, 32'h0, 0, 0, rand_side());
    flush = 1;
    tick(); flush = 0;
    reset = 1;
    tick(); reset = 0;
    issue(1, 1, 5'b0, 1, 5'd17, 32'h0, 0, 0, rand_side());
    data_ok = 1; rdata = 32'h0000_0077;
    #1;
    chk("rstdisc.valid", 32'(out_valid), 32'd1);
    chk("rstdisc.result", out_result, 32'h0000_0077);
    tick(); data_ok = 0;
    tick();

    // randomized traffic against the reference queue
    mq.delete();
    m_disc = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      int          n_out, first, kind, k;
      logic        hit, e_ov, e_ir;
      logic [31:0] e_res, e_wp;
      m_ent_t      ne, t;

      n_out = 0; first = -1;
      foreach (mq[j]) if (mq[j].is_mem && !mq[j].done) begin
        if (first < 0) first = j;
        n_out++;
      end
      flush     = ($urandom_range(0, 29) == 0) && (m_disc + n_out <= 8);
      data_ok   = (n_out > 0 || m_disc > 0) && ($urandom_range(0, 1) == 1);
      rdata     = $urandom();
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = !flush && ($urandom_range(0, 2) != 0);
      kind = $urandom_range(0, 2);
      k    = $urandom_range(0, 4);
      in_is_mem       = (kind != 0);
      in_res_from_mem = (kind == 1);
      in_ld_op        = (k == 4) ? 5'b0 : 5'(1 << k);
      in_gr_we        = 1'($urandom_range(0, 1));
      in_dest         = 5'($urandom_range(0, 31));
      in_result       = $urandom();
      in_ex           = ($urandom_range(0, 7) == 0);
      in_csr          = ($urandom_range(0, 7) == 0);
      in_side         = rand_side();
      if (data_ok && m_disc == 0 && n_out == 0) $error("protocol: unexpected data_ok");
      #1;

      hit  = data_ok && (m_disc == 0) && (first >= 0);
      e_ir = (mq.size() < DEPTH);
      e_ov = !flush && (mq.size() > 0);
      if (e_ov) e_ov = mq[0].done || (hit && first == 0);
      e_res = 32'd0;
      if (e_ov) e_res = mq[0].done ? mq[0].data
                      : (mq[0].rfm ? m_align(mq[0].ld_op, mq[0].result, rdata) : mq[0].result);
      e_wp = 32'd0;
      foreach (mq[j]) if (mq[j].gr_we) e_wp[mq[j].dest] = 1'b1;
      e_wp[0] = 1'b0;

      chk("rnd.in_ready", 32'(in_ready), 32'(e_ir));
      chk("rnd.out_valid", 32'(out_valid), 32'(e_ov));
      chk("rnd.out_result", out_result, e_res);
      chk("rnd.out_dest", 32'(out_dest), e_ov ? 32'(mq[0].dest) : 32'd0);
      chk("rnd.out_gr_we", 32'(out_gr_we), e_ov ? 32'(mq[0].gr_we) : 32'd0);
      chk_side("rnd.out_side", out_side, e_ov ? mq[0].side : '0);
      chk("rnd.wr_pending", wr_pending, e_wp);
      chk("rnd.ex_pending", 32'(ex_pending), 32'(mq.size() > 0 && (mq.find_first_index(x) with (x.ex)).size() > 0));
      chk("rnd.csr_pending", 32'(csr_pending), 32'(mq.size() > 0 && (mq.find_first_index(x) with (x.csr)).size() > 0));

      if (flush) begin
        m_disc = m_disc + n_out - (data_ok ? 1 : 0);
        if (m_disc < 0) m_disc = 0;
        mq.delete();
      end else begin
        if (data_ok) begin
          if (m_disc > 0) m_disc--;
          else if (first >= 0) begin
            t = mq[first];
            t.done = 1;
            if (t.rfm) t.data = m_align(t.ld_op, t.result, rdata);
            mq[first] = t;
          end
        end
        if (e_ov && out_ready) void'(mq.pop_front());
        if (in_valid && e_ir) begin
          ne.is_mem = in_is_mem; ne.rfm = in_res_from_mem; ne.ld_op = in_ld_op;
          ne.gr_we = in_gr_we; ne.dest = in_dest; ne.result = in_result;
          ne.ex = in_ex; ne.csr = in_csr; ne.side = in_side;
          ne.done = !in_is_mem; ne.data = in_result;
          mq.push_back(ne);
        end
      end
      tick();
    end

    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
